// File: rtl/rega_pkg.sv
// rtl/rega_pkg.sv - shared FSM encoding and default timing parameters for the level-sensor conditioner
package rega_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        REGA   = 2'b01,
        BLOQ   = 2'b10
    } estado_t;

    localparam int DEB_CYC_DEF   = 4;
    localparam int ASP_MIN_DEF   = 8;
    localparam int FALHA_CYC_DEF = 3;

endpackage

// File: rtl/cond_sens_nivel_if.sv
// rtl/cond_sens_nivel_if.sv - raw sensor inputs and conditioned outputs; man_req exists only with COND_SENS_MANUAL_EN
interface cond_sens_nivel_if;

    logic nv0_raw;
    logic nv1_raw;
    logic umid_raw;
    logic clr_falha;
`ifdef COND_SENS_MANUAL_EN
    logic man_req;
`endif
    logic Nv0;
    logic Nv1;
    logic Asp;
    logic Falha;

`ifdef COND_SENS_MANUAL_EN
    modport master (output nv0_raw, nv1_raw, umid_raw, clr_falha, man_req,
                    input  Nv0, Nv1, Asp, Falha);
    modport slave  (input  nv0_raw, nv1_raw, umid_raw, clr_falha, man_req,
                    output Nv0, Nv1, Asp, Falha);
`else
    modport master (output nv0_raw, nv1_raw, umid_raw, clr_falha,
                    input  Nv0, Nv1, Asp, Falha);
    modport slave  (input  nv0_raw, nv1_raw, umid_raw, clr_falha,
                    output Nv0, Nv1, Asp, Falha);
`endif

endinterface

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - single-bit debouncer, output flips after DEB_CYC consecutive disagreeing samples
module debounce_bit
    import rega_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_deb
);

    logic [7:0] r_cnt;
    logic       r_deb;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= 8'd0;
            r_deb <= 1'b0;
        end else if (i_raw == r_deb) begin
            r_cnt <= 8'd0;
        end else if (r_cnt == 8'(DEB_CYC - 1)) begin
            r_deb <= i_raw;
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/cond_sens_nivel.sv
// rtl/cond_sens_nivel.sv - debounced tank/soil sensors, plausibility fault latch and irrigation request FSM
// Optional manual request input enabled by macro COND_SENS_MANUAL_EN.
module cond_sens_nivel
    import rega_pkg::*;
#(
    parameter int DEB_CYC   = DEB_CYC_DEF,
    parameter int ASP_MIN   = ASP_MIN_DEF,
    parameter int FALHA_CYC = FALHA_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    cond_sens_nivel_if.slave   bus
);

    logic w_nv0;
    logic w_nv1;
    logic w_umid;
    logic w_implaus;
    logic w_falha_set;
    logic w_pedido;
    logic w_solta;

    logic [7:0]  r_fcnt;
    logic        r_falha;
    estado_t     r_state;
    logic [15:0] r_hold;
    logic        r_asp;

    debounce_bit #(.DEB_CYC(DEB_CYC)) u_deb_nv0 (
        .clk   (clk),
        .reset (reset),
        .i_raw (bus.nv0_raw),
        .o_deb (w_nv0)
    );

    debounce_bit #(.DEB_CYC(DEB_CYC)) u_deb_nv1 (
        .clk   (clk),
        .reset (reset),
        .i_raw (bus.nv1_raw),
        .o_deb (w_nv1)
    );

    debounce_bit #(.DEB_CYC(DEB_CYC)) u_deb_umid (
        .clk   (clk),
        .reset (reset),
        .i_raw (bus.umid_raw),
        .o_deb (w_umid)
    );

    // Upper sensor wet while lower is dry cannot happen with healthy sensors.
    assign w_implaus   = w_nv1 & ~w_nv0;
    assign w_falha_set = w_implaus && (r_fcnt >= 8'(FALHA_CYC - 1));

`ifdef COND_SENS_MANUAL_EN
    assign w_pedido = w_umid | bus.man_req;
    assign w_solta  = ~w_umid & ~bus.man_req;
`else
    assign w_pedido = w_umid;
    assign w_solta  = ~w_umid;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fcnt  <= 8'd0;
            r_falha <= 1'b0;
        end else begin
            if (!w_implaus)
                r_fcnt <= 8'd0;
            else if (r_fcnt < 8'(FALHA_CYC - 1))
                r_fcnt <= r_fcnt + 8'd1;

            if (w_falha_set)
                r_falha <= 1'b1;
            else if (bus.clr_falha && !w_implaus)
                r_falha <= 1'b0;
        end
    end

    // A fault rising on this edge already blocks entry to REGA from OCIOSO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= OCIOSO;
            r_hold  <= 16'd0;
            r_asp   <= 1'b0;
        end else begin
            case (r_state)
                OCIOSO: begin
                    if (r_falha || w_falha_set) begin
                        r_state <= BLOQ;
                        r_asp   <= 1'b0;
                    end else if (w_pedido) begin
                        r_state <= REGA;
                        r_hold  <= 16'd0;
                        r_asp   <= 1'b1;
                    end
                end
                REGA: begin
                    if (r_falha) begin
                        r_state <= BLOQ;
                        r_asp   <= 1'b0;
                    end else if (r_hold == 16'(ASP_MIN) && w_solta) begin
                        r_state <= OCIOSO;
                        r_asp   <= 1'b0;
                    end else if (r_hold != 16'(ASP_MIN)) begin
                        r_hold <= r_hold + 16'd1;
                    end
                end
                BLOQ: begin
                    if (!r_falha)
                        r_state <= OCIOSO;
                    r_asp <= 1'b0;
                end
                default: begin
                    r_state <= OCIOSO;
                    r_asp   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Nv0   = w_nv0;
    assign bus.Nv1   = w_nv1;
    assign bus.Asp   = r_asp;
    assign bus.Falha = r_falha;

endmodule

// File: tb/tb_cond_sens_nivel.sv
// tb/tb_cond_sens_nivel.sv - directed self-checking bench for cond_sens_nivel with default parameters
module tb_cond_sens_nivel;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    cond_sens_nivel_if bus();

    cond_sens_nivel dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.nv0_raw   = 1'b0;
        bus.nv1_raw   = 1'b0;
        bus.umid_raw  = 1'b0;
        bus.clr_falha = 1'b0;
`ifdef COND_SENS_MANUAL_EN
        bus.man_req   = 1'b0;
`endif
        ticks(2);
        chk("rst_nv0", bus.Nv0, 1'b0);
        chk("rst_nv1", bus.Nv1, 1'b0);
        chk("rst_asp", bus.Asp, 1'b0);
        chk("rst_falha", bus.Falha, 1'b0);
        reset = 1'b1;
        ticks(1);

        // 3-cycle glitch must not pass, then a held level rises on edge 4
        bus.nv0_raw = 1'b1;
        ticks(3);
        chk("glitch_nv0_e3", bus.Nv0, 1'b0);
        bus.nv0_raw = 1'b0;
        ticks(2);
        chk("glitch_nv0_gone", bus.Nv0, 1'b0);
        bus.nv0_raw = 1'b1;
        ticks(3);
        chk("nv0_e3", bus.Nv0, 1'b0);
        ticks(1);
        chk("nv0_e4", bus.Nv0, 1'b1);
        bus.nv0_raw = 1'b0;
        ticks(4);
        chk("nv0_fall_e4", bus.Nv0, 1'b0);

        // Irrigation request with ASP_MIN hold
        bus.umid_raw = 1'b1;
        ticks(4);
        chk("asp_e4", bus.Asp, 1'b0);
        ticks(1);
        chk("asp_e5", bus.Asp, 1'b1);
        ticks(2);
        bus.umid_raw = 1'b0;
        ticks(6);
        chk("asp_hold_e13", bus.Asp, 1'b1);
        ticks(1);
        chk("asp_drop_e14", bus.Asp, 1'b0);

        // Fault during REGA
        bus.umid_raw = 1'b1;
        ticks(5);
        chk("asp_again", bus.Asp, 1'b1);
        bus.nv1_raw = 1'b1;
        ticks(3);
        chk("nv1_e3", bus.Nv1, 1'b0);
        ticks(1);
        chk("nv1_e4", bus.Nv1, 1'b1);
        ticks(2);
        chk("falha_e6", bus.Falha, 1'b0);
        ticks(1);
        chk("falha_e7", bus.Falha, 1'b1);
        chk("asp_e7", bus.Asp, 1'b1);
        ticks(1);
        chk("asp_blocked_e8", bus.Asp, 1'b0);

        // Clear ignored while implausible, honoured once plausible
        bus.clr_falha = 1'b1;
        ticks(1);
        bus.clr_falha = 1'b0;
        chk("clr_ignored", bus.Falha, 1'b1);
        bus.nv0_raw = 1'b1;
        ticks(4);
        chk("nv0_plaus", bus.Nv0, 1'b1);
        chk("falha_latched", bus.Falha, 1'b1);
        bus.clr_falha = 1'b1;
        ticks(1);
        bus.clr_falha = 1'b0;
        chk("clr_ok", bus.Falha, 1'b0);
        chk("asp_bloq", bus.Asp, 1'b0);
        ticks(1);
        chk("asp_ocioso", bus.Asp, 1'b0);
        ticks(1);
        chk("asp_reenter", bus.Asp, 1'b1);

        // Reset mid-REGA with hold counter at 5
        ticks(5);
        reset = 1'b0;
        ticks(1);
        reset = 1'b1;
        chk("midrst_nv0", bus.Nv0, 1'b0);
        chk("midrst_nv1", bus.Nv1, 1'b0);
        chk("midrst_asp", bus.Asp, 1'b0);
        chk("midrst_falha", bus.Falha, 1'b0);
        ticks(4);
        chk("post_nv0_e4", bus.Nv0, 1'b1);
        chk("post_nv1_e4", bus.Nv1, 1'b1);
        chk("post_asp_e4", bus.Asp, 1'b0);
        ticks(1);
        chk("post_asp_e5", bus.Asp, 1'b1);
        bus.umid_raw = 1'b0;
        ticks(8);
        chk("post_hold_e13", bus.Asp, 1'b1);
        chk("post_falha", bus.Falha, 1'b0);
        ticks(1);
        chk("post_drop_e14", bus.Asp, 1'b0);

        // Fault rising on the edge OCIOSO would enter REGA: BLOQ wins
        reset = 1'b0;
        bus.nv0_raw  = 1'b0;
        bus.nv1_raw  = 1'b0;
        bus.umid_raw = 1'b0;
        ticks(1);
        reset = 1'b1;
        bus.nv1_raw = 1'b1;
        ticks(2);
        bus.umid_raw = 1'b1;
        ticks(5);
        chk("race_falha_e7", bus.Falha, 1'b1);
        chk("race_asp_e7", bus.Asp, 1'b0);
        ticks(1);
        chk("race_asp_e8", bus.Asp, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_sens_nivel.md
COND_SENS_NIVEL -- requirements
Module: cond_sens_nivel

Interface
REQ-001 Parameter DEB_CYC, default 4: consecutive disagreeing samples needed to change a debounced output; legal range 2..255.
REQ-002 Parameter ASP_MIN, default 8: minimum cycles Asp stays high once raised; legal range 1..65535.
REQ-003 Parameter FALHA_CYC, default 3: consecutive cycles of implausible level needed to raise Falha; legal range 1..255.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; reset=0 at a rising edge of clk resets the block.
REQ-006 nv0_raw  in  1  raw lower tank-level sensor; 1 means wet.
REQ-007 nv1_raw  in  1  raw upper tank-level sensor; 1 means wet.
REQ-008 umid_raw  in  1  raw soil sensor; 1 means dry, irrigation wanted.
REQ-009 clr_falha  in  1  one-cycle request to clear a latched fault.
REQ-010 Nv0  out  1  debounced lower level, registered.
REQ-011 Nv1  out  1  debounced upper level, registered.
REQ-012 Asp  out  1  irrigation request to the downstream tank/fertiliser controller.
REQ-013 Falha  out  1  latched sensor-plausibility fault.

Function
REQ-014 Each raw input SHALL pass through its own debouncer: the output flips on the DEB_CYC-th consecutive edge at which the sampled raw value differs from the output; any agreeing sample clears the count.
REQ-015 A raw glitch shorter than DEB_CYC cycles SHALL leave the debounced output unchanged.
REQ-016 Implausible level SHALL be defined as Nv1=1 with Nv0=0, using debounced values.
REQ-017 Falha SHALL rise on the FALHA_CYC-th consecutive edge with implausible level, and SHALL stay latched.
REQ-018 Falha SHALL clear on the edge sampling clr_falha=1 only when level is plausible on that edge; otherwise clr_falha is ignored.
REQ-019 Request FSM states: OCIOSO, REGA, BLOQ; Asp SHALL equal 1 exactly when state is REGA.
REQ-020 OCIOSO->REGA when debounced umid=1 and Falha=0; the ASP_MIN counter loads 0 on entry.
REQ-021 In REGA the counter SHALL increment each cycle and saturate at ASP_MIN; REGA->OCIOSO when counter=ASP_MIN and debounced umid=0.
REQ-022 Falha=1 in OCIOSO or REGA SHALL force the next state to BLOQ, overriding the ASP_MIN hold.
REQ-023 BLOQ->OCIOSO on the edge after Falha returns to 0; BLOQ never goes directly to REGA.
REQ-024 If Falha rises on the same edge that OCIOSO would enter REGA, BLOQ wins.

Reset
REQ-025 On reset: Nv0=0, Nv1=0, Asp=0, Falha=0; all debounce, fault and hold counters=0; state=OCIOSO.
REQ-026 Reset asserted mid-REGA or mid-debounce SHALL take effect on that edge; no partial count survives.

Configuration
REQ-027 Macro COND_SENS_MANUAL_EN: when defined, adds input man_req (1 bit); man_req=1 with Falha=0 SHALL also cause OCIOSO->REGA, and REGA exit additionally requires man_req=0.
REQ-028 Without COND_SENS_MANUAL_EN the man_req port SHALL not exist and behaviour is exactly REQ-020..REQ-024.

Structure
REQ-029 Shared package rega_pkg SHALL hold the FSM state encoding (OCIOSO=2'b00, REGA=2'b01, BLOQ=2'b10) and the default values of DEB_CYC, ASP_MIN and FALHA_CYC.
REQ-030 Debounce SHALL be one sub-module, debounce_bit (parameter DEB_CYC), instantiated three times.

Verification
REQ-031 nv0_raw 0->1 held; defaults -> Nv0 rises on the 4th edge; a 3-cycle pulse -> Nv0 stays 0.
REQ-032 umid_raw=1 held from cycle 0 -> Asp=1 from edge 5; umid_raw=0 at edge 7 -> Asp stays 1 until the ASP_MIN hold ends, then drops once debounced umid=0.
REQ-033 nv1_raw=1 with nv0_raw=0 held -> Nv1 at edge 4, Falha at edge 7; Asp during REGA -> 0 on edge 8.
REQ-034 clr_falha pulse while implausible -> Falha stays 1; nv0_raw=1 debounced, then clr_falha -> Falha=0, FSM returns to OCIOSO and re-enters REGA if umid is still dry.
REQ-035 reset=0 for one edge during REGA with counter=5 -> all outputs 0 next cycle; after release the hold counts a full 8 cycles again.
REQ-036 With COND_SENS_MANUAL_EN, man_req=1 and umid_raw=0 -> Asp=1 on the next edge; Asp holds while man_req=1, then drops after ASP_MIN.
